// File: rtl/inverse_permute_unit.sv
// Inverse pi-step lane permutation over a framed stream of 25-bit state slices.
// One slice per cycle in, registered result out, valid/ready on both sides.
module inverse_permute_unit #(
  parameter int unsigned NUM_SLICES = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inv_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      line_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      line_out,
  output logic [CNT_W-1:0] cnt_value,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [CNT_W-1:0] NumSlices = CNT_W'(NUM_SLICES);
  localparam logic [CNT_W-1:0] LastIdx   = CNT_W'(NUM_SLICES - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [24:0]      line_q, line_d;
  logic             done_q, done_d;

  logic [24:0]      perm;
  logic [24:0]      mapped;
  logic             in_ready_int;
  logic             accept;
  logic             fire;

  // Output lane (x,y) is fed from input lane (y, (2x+3y) mod 5).
  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_col
      assign perm[5*y + x] = line_in[5*((2*x + 3*y) % 5) + y];
    end
  end

  assign mapped = inv_en ? perm : line_in;

  assign in_ready_int = (state_q == StRun) && (!out_valid_q || out_ready) &&
                        (acc_cnt_q < NumSlices);
  assign accept       = in_valid && in_ready_int;
  assign fire         = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    acc_cnt_d   = acc_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    line_d      = line_q;
    done_d      = 1'b0;

    // A new accept refills the output register even when it fires on the same edge.
    if (accept) begin
      line_d      = mapped;
      out_valid_d = 1'b1;
    end else if (fire) begin
      out_valid_d = 1'b0;
    end

    if (fire && (out_cnt_q != NumSlices)) begin
      out_cnt_d = out_cnt_q + CntOne;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          acc_cnt_d = '0;
          out_cnt_d = '0;
        end
      end
      StRun: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CntOne;
          if (acc_cnt_q == LastIdx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (fire && (out_cnt_q == LastIdx)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      line_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      line_q      <= line_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_int;
  assign out_valid = out_valid_q;
  assign line_out  = line_q;
  assign cnt_value = out_cnt_q;
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = done_q;

endmodule

// File: tb/tb_inverse_permute_unit.sv
// Directed bench for inverse_permute_unit: per-frame expected tables, a negedge scoreboard
// for ordering/stability, and hand-computed map and protocol checks.
module tb_inverse_permute_unit;

  localparam int NUM = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        inv_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] line_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] line_out;
  logic [6:0]  cnt_value;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ts = 0;

  logic [24:0] frame_in  [NUM];
  logic [24:0] frame_exp [NUM];
  logic        frame_inv [NUM];
  logic [24:0] orig      [NUM];
  logic [24:0] exp_q [$];
  int          acc_idx = 0;
  bit          sb_on = 0;
  bit          hold_pending = 0;
  logic [24:0] hold_val = '0;
  logic [24:0] exp_word;

  inverse_permute_unit #(.NUM_SLICES(64), .CNT_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inv_en    (inv_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .line_in   (line_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .line_out  (line_out),
    .cnt_value (cnt_value),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] ref_inv(input logic [24:0] v);
    logic [24:0] r;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y + x] = v[5*((2*x + 3*y) % 5) + y];
    return r;
  endfunction

  function automatic logic [24:0] ref_fwd(input logic [24:0] v);
    logic [24:0] r;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*((2*x + 3*y) % 5) + y] = v[5*y + x];
    return r;
  endfunction

  // Scoreboard: expected word queued on accept, compared on fire; stalled output must hold.
  always @(negedge clk) begin
    if (sb_on) begin
      if (hold_pending) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {7'd0, line_out}, {7'd0, hold_val});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("fire_unexpected", 32'd1, 32'd0);
        end else begin
          exp_word = exp_q.pop_front();
          check("out_data", {7'd0, line_out}, {7'd0, exp_word});
        end
      end
      if (in_valid && in_ready) begin
        if (acc_idx < NUM) exp_q.push_back(frame_exp[acc_idx]);
        else check("over_accept", acc_idx, NUM - 1);
        acc_idx++;
      end
      hold_pending = out_valid && !out_ready;
      hold_val     = line_out;
    end
  end

  task automatic start_frame();
    @(posedge clk); #1;
    start = 1'b1;
    exp_q.delete();
    acc_idx = 0;
    hold_pending = 0;
    sb_on = 1;
    @(posedge clk); #1;
    start = 1'b0;
    ts = cyc;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_cnt", {25'd0, cnt_value}, 32'd0);
  endtask

  task automatic feed(input int first, input int n, input bit bp);
    int i = first;
    for (int c = 0; c < 4000 && i < first + n; c++) begin
      in_valid  = 1'b1;
      line_in   = frame_in[i];
      inv_en    = frame_inv[i];
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("feed_count", i, first + n);
  endtask

  task automatic wait_done(input bit bp);
    bit seen = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("cnt_final", {25'd0, cnt_value}, NUM);
    check("queue_empty", exp_q.size(), 0);
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_done_drops();
    @(posedge clk); #1;
    @(negedge clk);
    check("done_width", {31'd0, done}, 32'd0);
    check("cnt_hold", {25'd0, cnt_value}, NUM);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_line_out", {7'd0, line_out}, 32'd0);
    check("rst_cnt", {25'd0, cnt_value}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Hand-computed single bits, then a one-hot walk, then random fill
    frame_in[0] = 25'h0000002; frame_exp[0] = 25'h0000040; frame_inv[0] = 1'b1;
    frame_in[1] = 25'h0000020; frame_exp[1] = 25'h0000008; frame_inv[1] = 1'b1;
    frame_in[2] = 25'h0000001; frame_exp[2] = 25'h0000001; frame_inv[2] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      frame_in[3 + k]  = 25'd1 << k;
      frame_exp[3 + k] = ref_inv(25'd1 << k);
      frame_inv[3 + k] = 1'b1;
    end
    for (int k = 28; k < NUM; k++) begin
      frame_in[k]  = 25'($urandom());
      frame_exp[k] = ref_inv(frame_in[k]);
      frame_inv[k] = 1'b1;
    end
    start_frame();
    feed(0, NUM, 1'b0);
    wait_done(1'b0);
    check_done_drops();

    // Round trip through forward pi; full-rate frame fixes done latency
    for (int k = 0; k < NUM; k++) begin
      orig[k]      = 25'($urandom());
      frame_in[k]  = ref_fwd(orig[k]);
      frame_exp[k] = orig[k];
      frame_inv[k] = 1'b1;
    end
    start_frame();
    feed(0, NUM, 1'b0);
    wait_done(1'b0);
    check("done_latency", cyc - ts, 65);
    check_done_drops();

    // Random backpressure
    for (int k = 0; k < NUM; k++) begin
      frame_in[k]  = 25'($urandom());
      frame_exp[k] = ref_inv(frame_in[k]);
      frame_inv[k] = 1'b1;
    end
    start_frame();
    feed(0, NUM, 1'b1);
    wait_done(1'b1);
    check_done_drops();

    // Bypass and per-slice inv_en
    frame_in[0] = 25'h1ABCDEF; frame_exp[0] = 25'h1ABCDEF; frame_inv[0] = 1'b0;
    for (int k = 1; k < NUM; k++) begin
      frame_in[k]  = 25'($urandom());
      frame_inv[k] = k[0];
      frame_exp[k] = k[0] ? ref_inv(frame_in[k]) : frame_in[k];
    end
    start_frame();
    feed(0, NUM, 1'b0);
    wait_done(1'b0);
    check_done_drops();

    // in_valid while idle is ignored; count holds
    in_valid = 1'b1;
    line_in  = 25'h155AA55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);
      check("idle_busy", {30'd0, busy, out_valid}, 32'd0);
      check("idle_cnt", {25'd0, cnt_value}, NUM);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // start while busy is ignored
    start_frame();
    feed(0, 20, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_cnt", {25'd0, cnt_value}, 32'd20);
    check("busy_start_busy", {31'd0, busy}, 32'd1);
    feed(20, NUM - 20, 1'b0);
    wait_done(1'b0);

    // start coincident with done
    start = 1'b1;
    exp_q.delete();
    acc_idx = 0;
    hold_pending = 0;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_cnt", {25'd0, cnt_value}, 32'd0);
    feed(0, 10, 1'b0);

    // Asynchronous reset mid-frame
    sb_on = 0;
    in_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_line_out", {7'd0, line_out}, 32'd0);
    check("mid_rst_cnt", {25'd0, cnt_value}, 32'd0);
    check("mid_rst_busy_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {30'd0, busy, in_ready}, 32'd0);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
